sr_drive_sequencer: RTL and testbench
=====================================

// Module: sr_drive_sequencer
// PURPOSE
//  Write side of the SR flip-flop bank. Accepts a target bit-vector over a valid/ready handshake.
//  Produces timed, non-overlapping set/reset pulses (s_out/r_out) that move each SR flop to its
//  target value. Keeps a shadow copy of the driven state. Never drives s=r=1 on any channel.
// PARAMETERS
//  WIDTH     4   number of SR channels driven
//  PULSE_CYC 2   cycles each set/reset phase is held (>=1)
//  GAP_CYC   1   all-zero break cycles between set and reset phases (>=0)
//  INIT_Q    0   shadow value after reset (WIDTH bits); must match the SR bank reset value
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  tgt_valid  in   1      target vector valid
//  tgt_ready  out  1      block can accept a target (high only in IDLE)
//  tgt_data   in   WIDTH  requested SR output state
//  s_out      out  WIDTH  set pulses to SR bank
//  r_out      out  WIDTH  reset pulses to SR bank
//  busy       out  1      high in any state except IDLE
//  done       out  1      one-cycle pulse when an update completes
//  shadow_q   out  WIDTH  current believed SR bank state
//  q_fb       in   WIDTH  SR bank readback (only with SR_READBACK_CHECK_EN)
//  err        out  1      sticky readback mismatch (only with SR_READBACK_CHECK_EN)
// BEHAVIOUR
//  - Clock clk; reset rst is synchronous and active-high.
//  - Reset, including mid-operation: next edge gives state=IDLE, s_out=0, r_out=0, done=0,
//    busy=0, tgt_ready=1, shadow_q=INIT_Q, err=0, counter=0. An in-flight update is abandoned.
//  - Accept: on tgt_valid&&tgt_ready, latch set_m=tgt_data&~shadow_q and rst_m=~tgt_data&shadow_q.
//  - FSM states: IDLE, SET_PH, GAP, RST_PH, DONE. Transitions after accept:
//    set_m!=0             -> SET_PH
//    set_m==0, rst_m!=0   -> RST_PH
//    both zero            -> DONE
//  - SET_PH: s_out=set_m for PULSE_CYC cycles.
//    Exit to GAP if rst_m!=0 and GAP_CYC>0; to RST_PH if rst_m!=0 and GAP_CYC==0; else to DONE.
//    On exit, shadow_q|=set_m.
//  - GAP: s_out=r_out=0 for GAP_CYC cycles, then RST_PH.
//  - RST_PH: r_out=rst_m for PULSE_CYC cycles, then DONE. On exit, shadow_q&=~rst_m.
//  - DONE: done=1 for one cycle, then IDLE.
//  - Outputs are registered. Accept at edge k puts set pulses on cycles k+1..k+PULSE_CYC.
//  - Full update latency, accept edge to done high: 2*PULSE_CYC+GAP_CYC+1 cycles.
//    Skipped phases remove their cycles; a no-change update has done on cycle k+1.
//  - Invariants: (s_out&r_out)==0 in every cycle; s_out and r_out are never both nonzero in a cycle.
//  - tgt_data is ignored unless accepted. tgt_valid held while busy is not consumed.
//  - Phase counter width is $clog2(max(PULSE_CYC,GAP_CYC)+1). It reloads on each phase entry.
// CONFIGURATION
//  - Macro SR_READBACK_CHECK_EN. When defined, ports q_fb and err exist.
//    In DONE, if q_fb!=shadow_q then err<=1. err is sticky and is cleared only by rst.
//  - When the macro is undefined, q_fb and err are absent and no compare logic is built.
// STRUCTURE
//  - Package sr_drv_pkg: typedef enum sr_state_t {IDLE,SET_PH,GAP,RST_PH,DONE};
//    function to compute set/reset masks from target and shadow.
//  - Sub-module sr_phase_timer: loadable down-counter with zero flag, used for PULSE and GAP.
// TESTING (WIDTH=4, PULSE_CYC=2, GAP_CYC=1, INIT_Q=0)
//  1. rst, then tgt=4'b1010 -> s_out=1010 for 2 cycles, r_out stays 0; done on cycle k+3;
//     shadow_q=1010.
//  2. From 1010, tgt=4'b0110 -> s_out=0100 x2; gap x1; r_out=1000 x2; done on cycle k+6;
//     shadow_q=0110.
//  3. From 0110, tgt=4'b0110 -> no pulses; done on cycle k+1; tgt_ready low only for 1 cycle.
//  4. Assert rst during RST_PH of scenario 2 -> next cycle s_out=r_out=0, IDLE, shadow_q=0000.
//  5. Hold tgt_valid high with changing data while busy -> only the value accepted in IDLE is
//     applied. A bench assertion checks (s_out&r_out)==0 on every cycle.
//  6. With SR_READBACK_CHECK_EN, force q_fb=0000 during DONE of scenario 1 -> err=1 and stays 1
//     until rst.

Source files
------------

// File: rtl/sr_drive_sequencer_pkg.sv
// Shared types and mask helpers for the SR drive sequencer.
// Build option SR_READBACK_CHECK_EN is handled in the top module, not here.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET_PH,
    GAP,
    RST_PH,
    DONE
  } sr_state_t;

  // The helpers work on a generous fixed width; callers narrow the result to their channel count.
  localparam int SR_MAX_WIDTH = 32;
  typedef logic [SR_MAX_WIDTH-1:0] sr_vec_t;

  // Bits that must go 0->1 to reach the target.
  function automatic sr_vec_t sr_set_mask(input sr_vec_t tgt, input sr_vec_t shadow);
    return tgt & ~shadow;
  endfunction

  // Bits that must go 1->0 to reach the target.
  function automatic sr_vec_t sr_rst_mask(input sr_vec_t tgt, input sr_vec_t shadow);
    return ~tgt & shadow;
  endfunction

endpackage

// File: rtl/sr_drive_sequencer_if.sv
// Target-vector valid/ready handshake into the SR drive sequencer.
interface sr_drive_sequencer_if #(
  parameter int WIDTH = 4
) ();

  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready
  );

endinterface

// File: rtl/sr_drive_sequencer_phase_timer.sv
// Loadable down-counter that times the set, gap and reset phases.
// The zero flag marks the last cycle of the current phase.
module sr_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // NOTE: synchronous reset, so rst is only tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_drive_sequencer.sv
// Write side of an SR flip-flop bank: turns a target vector into non-overlapping set/reset pulses.
// Optional readback compare (q_fb, err) is built when SR_READBACK_CHECK_EN is defined.
module sr_drive_sequencer
  import sr_drv_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               PULSE_CYC = 2,
  parameter int               GAP_CYC   = 1,
  parameter logic [WIDTH-1:0] INIT_Q    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_drive_sequencer_if.slave  tgt,
  output logic [WIDTH-1:0]     s_out,
  output logic [WIDTH-1:0]     r_out,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     shadow_q
`ifdef SR_READBACK_CHECK_EN
  ,
  input  logic [WIDTH-1:0]     q_fb,
  output logic                 err
`endif
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  // The timer counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  sr_state_t        state;
  logic             ready_q;
  logic [WIDTH-1:0] set_m;
  logic [WIDTH-1:0] rst_m;
  logic [WIDTH-1:0] set_nx;
  logic [WIDTH-1:0] rst_nx;
  logic             accept;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  assign tgt.tgt_ready = ready_q;
  assign accept        = tgt.tgt_valid && ready_q;

  assign set_nx = WIDTH'(sr_set_mask(sr_vec_t'(tgt.tgt_data), sr_vec_t'(shadow_q)));
  assign rst_nx = WIDTH'(sr_rst_mask(sr_vec_t'(tgt.tgt_data), sr_vec_t'(shadow_q)));

  // Timer reload is decoded from the same conditions that move the FSM into a timed phase.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    case (state)
      IDLE:    tmr_load = accept && ((set_nx != '0) || (rst_nx != '0));
      SET_PH: begin
        if (tmr_zero && (rst_m != '0)) begin
          tmr_load = 1'b1;
          tmr_val  = (GAP_CYC > 0) ? GAP_LD : PULSE_LD;
        end
      end
      GAP:     tmr_load = tmr_zero;
      default: ;
    endcase
  end

  sr_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  // NOTE: state and outputs use non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_out    <= '0;
      r_out    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ready_q  <= 1'b1;
      shadow_q <= INIT_Q;
      set_m    <= '0;
      rst_m    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            set_m   <= set_nx;
            rst_m   <= rst_nx;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            if (set_nx != '0) begin
              state <= SET_PH;
              s_out <= set_nx;
            end else if (rst_nx != '0) begin
              state <= RST_PH;
              r_out <= rst_nx;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SET_PH: begin
          if (tmr_zero) begin
            s_out    <= '0;
            shadow_q <= shadow_q | set_m;
            if ((rst_m != '0) && (GAP_CYC > 0)) begin
              state <= GAP;
            end else if (rst_m != '0) begin
              state <= RST_PH;
              r_out <= rst_m;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        GAP: begin
          if (tmr_zero) begin
            state <= RST_PH;
            r_out <= rst_m;
          end
        end

        RST_PH: begin
          if (tmr_zero) begin
            r_out    <= '0;
            shadow_q <= shadow_q & ~rst_m;
            state    <= DONE;
            done     <= 1'b1;
          end
        end

        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          s_out   <= '0;
          r_out   <= '0;
          busy    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef SR_READBACK_CHECK_EN
  // Shadow is already final in DONE, so that is where the bank readback is trusted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == DONE) && (q_fb != shadow_q)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Self-checking bench for sr_drive_sequencer: directed scenarios plus randomized targets
// checked against a per-cycle pulse schedule derived from the target/shadow rules.
module tb_sr_drive_sequencer;

  localparam int WIDTH     = 4;
  localparam int PULSE_CYC = 2;
  localparam int GAP_CYC   = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shadow_q;
`ifdef SR_READBACK_CHECK_EN
  logic [WIDTH-1:0] q_fb;
  logic             err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] model_shadow;
  logic [WIDTH-1:0] bank;
  bit               force_fb_zero = 1'b0;
  bit               watch_overlap = 1'b0;

  sr_drive_sequencer_if #(.WIDTH(WIDTH)) bus ();

  sr_drive_sequencer #(
    .WIDTH    (WIDTH),
    .PULSE_CYC(PULSE_CYC),
    .GAP_CYC  (GAP_CYC),
    .INIT_Q   (4'b0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tgt     (bus),
    .s_out   (s_out),
    .r_out   (r_out),
    .busy    (busy),
    .done    (done),
    .shadow_q(shadow_q)
`ifdef SR_READBACK_CHECK_EN
    ,
    .q_fb    (q_fb),
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SR bank driven by the pulses, used as readback source.
  always @(posedge clk) begin
    if (rst) bank <= 4'b0000;
    else     bank <= (bank | s_out) & ~r_out;
  end
`ifdef SR_READBACK_CHECK_EN
  assign q_fb = force_fb_zero ? 4'b0000 : bank;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set and reset pulses must never overlap on any cycle.
  always @(negedge clk) begin
    if (watch_overlap) begin
      check("no_overlap", 32'(s_out & r_out), 32'd0);
      check("single_phase", 32'((|s_out) && (|r_out)), 32'd0);
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ready"},  32'(bus.tgt_ready), 32'd1);
    check({tag, "_busy"},   32'(busy),          32'd0);
    check({tag, "_done"},   32'(done),          32'd0);
    check({tag, "_s"},      32'(s_out),         32'd0);
    check({tag, "_r"},      32'(r_out),         32'd0);
    check({tag, "_shadow"}, 32'(shadow_q),      32'(model_shadow));
  endtask

  // One full update: schedule of expected (s, r, done) per cycle after the accept edge.
  task automatic do_update(input logic [WIDTH-1:0] tgt, input bit hold);
    logic [WIDTH-1:0] sm, rm;
    logic [WIDTH-1:0] q_s[$];
    logic [WIDTH-1:0] q_r[$];
    bit               q_d[$];
    int               n;
    sm = tgt & ~model_shadow;
    rm = ~tgt & model_shadow;
    if (sm != 0) repeat (PULSE_CYC) begin q_s.push_back(sm); q_r.push_back('0); q_d.push_back(0); end
    if (sm != 0 && rm != 0) repeat (GAP_CYC) begin q_s.push_back('0); q_r.push_back('0); q_d.push_back(0); end
    if (rm != 0) repeat (PULSE_CYC) begin q_s.push_back('0); q_r.push_back(rm); q_d.push_back(0); end
    q_s.push_back('0); q_r.push_back('0); q_d.push_back(1);

    n = 0;
    while (!bus.tgt_ready && n < 50) begin step(); n++; end
    check("ready_before_accept", 32'(bus.tgt_ready), 32'd1);

    bus.tgt_valid = 1'b1;
    bus.tgt_data  = tgt;
    step();
    for (int i = 0; i < q_s.size(); i++) begin
      check("s_out",     32'(s_out),         32'(q_s[i]));
      check("r_out",     32'(r_out),         32'(q_r[i]));
      check("done",      32'(done),          32'(q_d[i]));
      check("busy",      32'(busy),          32'd1);
      check("ready_low", 32'(bus.tgt_ready), 32'd0);
      if (hold && !q_d[i]) begin
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = WIDTH'($urandom);
      end else begin
        bus.tgt_valid = 1'b0;
      end
      step();
    end
    model_shadow = tgt;
    check_idle("after_update");
  endtask

  initial begin
    rst           = 1'b1;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    model_shadow  = 4'b0000;
    step();
    step();
    watch_overlap = 1'b1;
    check_idle("reset");
`ifdef SR_READBACK_CHECK_EN
    check("reset_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    step();

    // Set-only, set+gap+reset, and no-change updates.
    do_update(4'b1010, 1'b0);
    do_update(4'b0110, 1'b0);
    do_update(4'b0110, 1'b0);
    do_update(4'b0000, 1'b0);

    // Reset mid-update during the reset phase.
    do_update(4'b1010, 1'b0);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b0110;
    step();
    bus.tgt_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (r_out == '0 && n < 20) begin step(); n++; end
      check("rst_ph_reached", 32'(r_out), 32'(4'b1000));
    end
    rst = 1'b1;
    step();
    model_shadow = 4'b0000;
    check_idle("mid_reset");
    rst = 1'b0;
    step();

    // Valid held high with changing data while busy.
    do_update(4'b1100, 1'b1);
    do_update(4'b0011, 1'b1);

    // Randomized targets, optional held valid, random idle spacing.
    for (int t = 0; t < 24; t++) begin
      do_update(WIDTH'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

`ifdef SR_READBACK_CHECK_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_shadow = 4'b0000;
    step();
    check("err_clear", 32'(err), 32'd0);
    force_fb_zero = 1'b1;
    do_update(4'b1010, 1'b0);
    force_fb_zero = 1'b0;
    check("err_set", 32'(err), 32'd1);
    do_update(4'b0101, 1'b0);
    check("err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    step();
    check("err_rst", 32'(err), 32'd0);
    rst = 1'b0;
    step();
`endif

    watch_overlap = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
